// File: rtl/pipe_arb_pkg.sv
// ---------------------------------------------------------------------------
// pipe_arb_pkg
// Shared definitions for the pipelined-unit sharing arbiter:
//   clog2   - ceiling log2, used to size pointers and counters
//   tag_t   - one stage of the tag tracker {vld, id}
// TAG_ID_W is wide enough for the largest supported requester count (16).
// ---------------------------------------------------------------------------
package pipe_arb_pkg;

    localparam int TAG_ID_W = 4;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin search: grants the first eligible
// requester at or above ptr, wrapping to index 0 if none is found there.
// Ports:
//   eligible  in   N_REQ  requesters allowed to win this cycle
//   ptr       in   PTR_W  index with highest priority this cycle
//   grant     out  N_REQ  one-hot-or-zero winner
// ---------------------------------------------------------------------------
module rr_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    logic found;

    // Two passes: first the indices at or above ptr, then the wrapped
    // part below ptr. The found flag keeps the result one-hot.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise synthesis infers a latch.
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && eligible[i] && (i >= int'(ptr))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && eligible[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_share_arbiter.sv
// ---------------------------------------------------------------------------
// pipe_share_arbiter
// Shares one fixed-latency (DEPTH-cycle) pipelined unit between N_REQ
// requesters. A round-robin grant forwards one request per cycle into the
// unit; a DEPTH-stage tag tracker remembers who owns each slot so results
// are steered back to their requester. Each requester may have at most
// MAX_OUT transfers in flight.
// Ports:
//   clk            in   1            clock, rising edge
//   rst            in   1            asynchronous active-low reset
//   req_vld        in   N_REQ        request valid per requester
//   req_data       in   N_REQ*WIDTH  request operands, [i*WIDTH +: WIDTH]
//   req_rdy        out  N_REQ        one-hot-or-zero accept (the grant)
//   pipe_in_vld    out  1            valid into the shared unit
//   pipe_in_data   out  WIDTH        operand into the shared unit
//   pipe_out_vld   in   1            valid from the shared unit
//   pipe_out_data  in   WIDTH        result from the shared unit
//   res_vld        out  N_REQ        one-hot-or-zero result strobe
//   res_data       out  WIDTH        result data, shared by all requesters
//   err            out  1            sticky tag/valid mismatch flag
// ---------------------------------------------------------------------------
module pipe_share_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int MAX_OUT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_vld,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_rdy,
    output logic                   pipe_in_vld,
    output logic [WIDTH-1:0]       pipe_in_data,
    input  logic                   pipe_out_vld,
    input  logic [WIDTH-1:0]       pipe_out_data,
    output logic [N_REQ-1:0]       res_vld,
    output logic [WIDTH-1:0]       res_data,
    output logic                   err
);

    localparam int PTR_W = (N_REQ > 1) ? clog2(N_REQ) : 1;
    localparam int CNT_W = clog2(MAX_OUT + 1);

    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    rr_next;
    logic [CNT_W-1:0]    outstanding [N_REQ];
    logic [N_REQ-1:0]    eligible;
    logic [N_REQ-1:0]    tag_ret;
    logic [N_REQ-1:0]    arb_grant;
    logic [N_REQ-1:0]    grant;
    logic                grant_any;
    logic [TAG_ID_W-1:0] grant_idx;
    logic [DEPTH-1:0]    tag_vld;
    logic [TAG_ID_W-1:0] tag_id [DEPTH];
    tag_t                last_tag;

    assign last_tag.vld = tag_vld[DEPTH-1];
    assign last_tag.id  = tag_id[DEPTH-1];

    // tag_ret[i]: a slot owned by requester i leaves the tracker this cycle.
    // That slot is freed in the same cycle, so a requester sitting at
    // MAX_OUT may be granted again exactly when its result returns.
    always_comb begin
        tag_ret  = '0;
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            tag_ret[i]  = last_tag.vld && (last_tag.id == TAG_ID_W'(i));
            eligible[i] = req_vld[i] &&
                          ((outstanding[i] < CNT_W'(MAX_OUT)) || tag_ret[i]);
        end
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .grant    (arb_grant)
    );

    // Gating with rst keeps the accept low while reset is asserted,
    // even though the counters already read zero then.
    assign grant     = arb_grant & {N_REQ{rst}};
    assign grant_any = |grant;
    assign req_rdy   = grant;

    always_comb begin
        grant_idx    = '0;
        pipe_in_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_idx    = TAG_ID_W'(i);
                pipe_in_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign pipe_in_vld = grant_any;

    always_comb begin
        rr_next = rr_ptr;
        if (grant_any) begin
            if (int'(grant_idx) == N_REQ - 1) begin
                rr_next = '0;
            end else begin
                rr_next = PTR_W'(int'(grant_idx) + 1);
            end
        end
    end

    // Result steering is purely combinational: no latency beyond the unit.
    always_comb begin
        res_vld = '0;
        for (int i = 0; i < N_REQ; i++) begin
            res_vld[i] = pipe_out_vld && tag_ret[i];
        end
    end

    assign res_data = pipe_out_data;

    // Control state: pointer, counters, tag valids, sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: registered state always uses non-blocking assignments so
            // every flop samples pre-edge values regardless of statement order.
            rr_ptr  <= '0;
            tag_vld <= '0;
            err     <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                outstanding[i] <= '0;
            end
        end else begin
            rr_ptr     <= rr_next;
            tag_vld[0] <= grant_any;
            for (int k = 1; k < DEPTH; k++) begin
                tag_vld[k] <= tag_vld[k-1];
            end
            // Any disagreement between the unit and the tracker is latched.
            if (pipe_out_vld != last_tag.vld) begin
                err <= 1'b1;
            end
            // A returning tag decrements its owner even when the unit failed
            // to present a valid, so the requester cannot lock up.
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i] && !(tag_ret[i] && (outstanding[i] != '0))) begin
                    outstanding[i] <= outstanding[i] + CNT_W'(1);
                end else if (!grant[i] && tag_ret[i] && (outstanding[i] != '0)) begin
                    outstanding[i] <= outstanding[i] - CNT_W'(1);
                end
            end
        end
    end

    // NOTE: the id payload is deliberately left out of reset; it is only
    // ever consumed qualified by tag_vld, which is reset.
    always_ff @(posedge clk) begin
        tag_id[0] <= grant_idx;
        for (int k = 1; k < DEPTH; k++) begin
            tag_id[k] <= tag_id[k-1];
        end
    end

endmodule
